// File: rtl/add_accumulator.sv
// add_accumulator: folds a stream of num_ops 8-bit operands into one sum
// through an internal ripple-carry adder, tracks unsigned wrap, and hands
// the final sum downstream with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start, no operand or result handshake
// ACCUM | accepting operands until remaining reaches zero
// DONE  | result held on sum/overflow until out_ready

module add (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s
);

  logic [7:0] c;

  // Ripple-carry chain; the carry out of bit 7 is not exposed.
  always_comb begin
    c    = '0;
    s    = '0;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      if (i < 7) c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

endmodule

module add_accumulator (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] num_ops,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] sum,
  output logic       overflow,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t     state;
  logic [7:0] acc;
  logic [3:0] remaining;
  logic       ovf;
  logic [7:0] add_sum;

  add u_add (
    .a (acc),
    .b (in_data),
    .s (add_sum)
  );

  // Sequencer and datapath registers; a result below the old sum means wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= num_ops;
            state     <= (num_ops == 4'd0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc       <= add_sum;
            ovf       <= ovf | (add_sum < acc);
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = acc;
  assign overflow  = ovf;

endmodule

// File: tb/tb_add_accumulator.sv
// Directed bench for add_accumulator with hand-computed expected sums.

module tb_add_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] num_ops = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] sum;
  logic       overflow;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         n_acc = 0;
  logic [7:0] ops [16];

  add_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_ops   (num_ops),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Free-running edge counter and accepted-operand counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && in_valid && in_ready) n_acc <= n_acc + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_job(input logic [3:0] n);
    start   = 1'b1;
    num_ops = n;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    int   i = 0;
    int   guard = 0;
    logic rdy;
    while (i < n && guard < 400) begin
      in_valid = gaps ? ((guard % 3) != 1) : 1'b1;
      in_data  = ops[i];
      rdy      = in_ready;
      @(posedge clk);
      if (in_valid && rdy) i++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (i < n) check("feed_timeout", 16'(i), 16'(n));
  endtask

  task automatic wait_done(output int t);
    int g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!out_valid) check("done_timeout", 16'(out_valid), 16'd1);
    t = cyc;
  endtask

  task automatic finish_job(input string tag, input logic [7:0] es, input logic eo);
    int t;
    wait_done(t);
    check({tag, "_sum"}, 16'(sum), 16'(es));
    check({tag, "_ovf"}, 16'(overflow), 16'(eo));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_busy"}, 16'(busy), 16'd0);
    check({tag, "_idle_valid"}, 16'(out_valid), 16'd0);
    check({tag, "_sum_hold"}, 16'(sum), 16'(es));
  endtask

  initial begin
    int t0, t1, a0;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_sum", 16'(sum), 16'h00);
    check("rst_ovf", 16'(overflow), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);

    // Three operands with in_valid held high: 5+10+20 = 0x23.
    ops[0] = 8'h05; ops[1] = 8'h0A; ops[2] = 8'h14;
    start_job(4'd3);
    t0 = cyc;
    check("j1_in_ready", 16'(in_ready), 16'd1);
    feed(3, 1'b0);
    wait_done(t1);
    check("j1_latency", 16'(t1 - t0 + 1), 16'd4);
    finish_job("j1", 8'h23, 1'b0);

    // 0xF0 + 0x20 wraps to 0x10.
    ops[0] = 8'hF0; ops[1] = 8'h20;
    start_job(4'd2);
    feed(2, 1'b0);
    finish_job("j2", 8'h10, 1'b1);

    // Overflow cleared at start.
    ops[0] = 8'h01;
    start_job(4'd1);
    feed(1, 1'b0);
    finish_job("j3", 8'h01, 1'b0);

    // Zero operands: straight to DONE with sum 0, nothing consumed.
    a0       = n_acc;
    in_valid = 1'b1;
    in_data  = 8'h55;
    start_job(4'd0);
    check("j0_out_valid", 16'(out_valid), 16'd1);
    check("j0_sum", 16'(sum), 16'h00);
    check("j0_in_ready", 16'(in_ready), 16'd0);
    in_valid = 1'b0;
    check("j0_accepted", 16'(n_acc - a0), 16'd0);
    finish_job("j0", 8'h00, 1'b0);

    // Fifteen operands of 0x11 with in_valid gaps: 15*0x11 = 0xFF.
    for (int i = 0; i < 16; i++) ops[i] = 8'h11;
    a0 = n_acc;
    check("j15_idle_in_ready", 16'(in_ready), 16'd0);
    start_job(4'd15);
    feed(15, 1'b1);
    wait_done(t1);
    check("j15_accepted", 16'(n_acc - a0), 16'd15);
    check("j15_done_in_ready", 16'(in_ready), 16'd0);

    // Hold DONE with out_ready low while pulsing start.
    for (int k = 0; k < 5; k++) begin
      start   = (k % 2) == 0;
      num_ops = 4'd3;
      @(posedge clk);
      @(negedge clk);
      check("hold_sum", 16'(sum), 16'hFF);
      check("hold_ovf", 16'(overflow), 16'd0);
      check("hold_valid", 16'(out_valid), 16'd1);
    end
    start = 1'b0;
    finish_job("j15", 8'hFF, 1'b0);

    // Reset mid-ACCUM after 2 of 4 operands, with a pending handshake.
    ops[0] = 8'h10; ops[1] = 8'h20;
    start_job(4'd4);
    feed(2, 1'b0);
    check("pre_rst_sum", 16'(sum), 16'h30);
    in_valid = 1'b1;
    in_data  = 8'h40;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_sum", 16'(sum), 16'h00);
    check("mid_rst_ovf", 16'(overflow), 16'd0);
    check("mid_rst_in_ready", 16'(in_ready), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_out_valid", 16'(out_valid), 16'd0);
    ops[0] = 8'h07;
    start_job(4'd1);
    feed(1, 1'b0);
    finish_job("j_after_rst", 8'h07, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
